// File: rtl/instruction_fetch_stage.sv
// MIPS IF stage: holds the PC, drives the combinational imem address and loads the IF/ID register.
// Redirect from EX overrides a stall; a stall freezes PC and IF/ID together.
module instruction_fetch_stage #(
   parameter logic [31:0] PC_RESET  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
   output logic [31:0] fetch_count,
   output logic        misalign_err
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] if_id_instr_q, if_id_instr_d;
   logic [31:0] if_id_pc4_q, if_id_pc4_d;
   logic        if_id_valid_q, if_id_valid_d;
   logic [31:0] fetch_count_q, fetch_count_d;
   logic        misalign_err_q, misalign_err_d;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      pc_d           = pc_q;
      if_id_instr_d  = if_id_instr_q;
      if_id_pc4_d    = if_id_pc4_q;
      if_id_valid_d  = if_id_valid_q;
      fetch_count_d  = fetch_count_q;
      misalign_err_d = misalign_err_q;
      if (redirect) begin
         // Target low bits are dropped so imem_addr can never be misaligned.
         pc_d          = redirect_target & ~32'h3;
         if_id_instr_d = NOP_INSTR;
         if_id_pc4_d   = 32'd0;
         if_id_valid_d = 1'b0;
         if (redirect_target[1:0] != 2'b00)
            misalign_err_d = 1'b1;
      end else if (!stall) begin
         pc_d          = pc_plus4;
         if_id_instr_d = imem_rdata;
         if_id_pc4_d   = pc_plus4;
         if_id_valid_d = 1'b1;
         fetch_count_d = fetch_count_q + 32'd1;
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         pc_q           <= PC_RESET;
         if_id_instr_q  <= NOP_INSTR;
         if_id_pc4_q    <= 32'd0;
         if_id_valid_q  <= 1'b0;
         fetch_count_q  <= 32'd0;
         misalign_err_q <= 1'b0;
      end else begin
         pc_q           <= pc_d;
         if_id_instr_q  <= if_id_instr_d;
         if_id_pc4_q    <= if_id_pc4_d;
         if_id_valid_q  <= if_id_valid_d;
         fetch_count_q  <= fetch_count_d;
         misalign_err_q <= misalign_err_d;
      end
   end

   assign imem_addr    = pc_q;
   assign if_id_instr  = if_id_instr_q;
   assign if_id_pc4    = if_id_pc4_q;
   assign if_id_valid  = if_id_valid_q;
   assign fetch_count  = fetch_count_q;
   assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed vector table plus an async-reset sequence.
module tb_instruction_fetch_stage;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_target = 32'd0;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic [31:0] fetch_count;
   logic        misalign_err;

   int checks = 0;
   int errors = 0;

   instruction_fetch_stage dut (
      .Clk             (Clk),
      .Rst             (Rst),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .imem_addr       (imem_addr),
      .imem_rdata      (imem_rdata),
      .if_id_instr     (if_id_instr),
      .if_id_pc4       (if_id_pc4),
      .if_id_valid     (if_id_valid),
      .fetch_count     (fetch_count),
      .misalign_err    (misalign_err)
   );

   always #5 Clk = ~Clk;

   // Instruction memory model: word at address 0 is 0x20080005, distinct per address.
   function automatic logic [31:0] imem_word(input logic [31:0] a);
      return 32'h2008_0005 + a;
   endfunction

   assign imem_rdata = imem_word(imem_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                            input logic [31:0] e_pc4, input logic e_valid,
                            input logic [31:0] e_cnt, input logic e_mis);
      check({tag, " pc"},    imem_addr,           e_pc);
      check({tag, " instr"}, if_id_instr,         e_instr);
      check({tag, " pc4"},   if_id_pc4,           e_pc4);
      check({tag, " valid"}, {31'd0, if_id_valid}, {31'd0, e_valid});
      check({tag, " count"}, fetch_count,         e_cnt);
      check({tag, " mis"},   {31'd0, misalign_err}, {31'd0, e_mis});
   endtask

   typedef struct {
      logic        stall;
      logic        redirect;
      logic [31:0] target;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      logic [31:0] e_pc4;
      logic        e_valid;
      logic [31:0] e_cnt;
      logic        e_mis;
   } vec_t;

   localparam int NVEC = 16;
   vec_t vecs[NVEC];

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //          stall redir target        pc             instr                 pc4           v     cnt  mis
      vecs[0]  = '{1'b0, 1'b0, 32'h0,        32'h4,        imem_word(32'h0),     32'h4,        1'b1, 1, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 32'h0,        32'h8,        imem_word(32'h4),     32'h8,        1'b1, 2, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 32'h0,        32'h8,        imem_word(32'h4),     32'h8,        1'b1, 2, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 32'h0,        32'h8,        imem_word(32'h4),     32'h8,        1'b1, 2, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 32'h0,        32'hC,        imem_word(32'h8),     32'hC,        1'b1, 3, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 32'h0,        32'h10,       imem_word(32'hC),     32'h10,       1'b1, 4, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 32'h40,       32'h40,       32'h0,                32'h0,        1'b0, 4, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 32'h0,        32'h44,       imem_word(32'h40),    32'h44,       1'b1, 5, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 32'h100,      32'h100,      32'h0,                32'h0,        1'b0, 5, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 32'h103,      32'h100,      32'h0,                32'h0,        1'b0, 5, 1'b1};
      vecs[10] = '{1'b0, 1'b0, 32'h0,        32'h104,      imem_word(32'h100),   32'h104,      1'b1, 6, 1'b1};
      vecs[11] = '{1'b0, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,                32'h0,        1'b0, 6, 1'b1};
      vecs[12] = '{1'b0, 1'b0, 32'h0,        32'h0,        imem_word(32'hFFFFFFFC), 32'h0,     1'b1, 7, 1'b1};
      vecs[13] = '{1'b1, 1'b0, 32'h0,        32'h0,        imem_word(32'hFFFFFFFC), 32'h0,     1'b1, 7, 1'b1};
      vecs[14] = '{1'b0, 1'b1, 32'h20,       32'h20,       32'h0,                32'h0,        1'b0, 7, 1'b1};
      vecs[15] = '{1'b0, 1'b0, 32'h0,        32'h24,       imem_word(32'h20),    32'h24,       1'b1, 8, 1'b1};

      // Reset held: check before and after a clock edge.
      #2;
      check_all("rst0", 32'h0, 32'h0, 32'h0, 1'b0, 0, 1'b0);
      @(posedge Clk); #1;
      check_all("rst1", 32'h0, 32'h0, 32'h0, 1'b0, 0, 1'b0);
      @(negedge Clk);
      Rst = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         stall           = vecs[i].stall;
         redirect        = vecs[i].redirect;
         redirect_target = vecs[i].target;
         @(posedge Clk); #1;
         check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pc4,
                   vecs[i].e_valid, vecs[i].e_cnt, vecs[i].e_mis);
         @(negedge Clk);
      end

      // Async reset between edges, while stall and redirect are both requested.
      stall           = 1'b1;
      redirect        = 1'b1;
      redirect_target = 32'h80;
      #2;
      Rst = 1'b1;
      #1;
      check_all("async", 32'h0, 32'h0, 32'h0, 1'b0, 0, 1'b0);
      @(posedge Clk); #1;
      check_all("async_edge", 32'h0, 32'h0, 32'h0, 1'b0, 0, 1'b0);

      // First edge after release fetches from PC_RESET with no bubble.
      @(negedge Clk);
      stall    = 1'b0;
      redirect = 1'b0;
      Rst      = 1'b0;
      @(posedge Clk); #1;
      check_all("post_rst", 32'h4, imem_word(32'h0), 32'h4, 1'b1, 1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
